regfile_32x64: RTL and testbench

REGFILE_32X64 -- requirements
Module: regfile_32x64

---
 rtl/regfile_pkg.sv | 12 +
 rtl/dec5_32_en.sv | 20 ++
 rtl/regfile_32x64.sv | 75 +++++++
 tb/tb_regfile_32x64.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the 32 x 64-bit register file and its write decoder.
package regfile_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  // X31 is the zero register: it is never stored and always reads as zero.
  localparam int XZR_IDX  = 31;

  typedef logic [NUM_REGS-1:0] word_en_t;

endpackage

// File: rtl/dec5_32_en.sv
// 5-to-32 enabled decoder: one-hot word enables for the register file write port.
module dec5_32_en
  import regfile_pkg::*;
(
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output word_en_t          onehot
);

  // Exactly one enable high when en is 1; all low when en is 0 (or unknown).
  always_comb begin
    // NOTE: the all-zero default ahead of the conditional assigns every bit on every
    // path, so no latch can be inferred.
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_32x64.sv
// 32-entry register file with one write port and two combinational read ports.
// Address 31 is XZR: it reads as zero and writes to it are dropped.
module regfile_32x64 #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);

  import regfile_pkg::NUM_REGS;
  import regfile_pkg::XZR_IDX;
  import regfile_pkg::word_en_t;

  // Only X0..X30 hold state; X31 has no storage behind it.
  localparam int NUM_STORED = NUM_REGS - 1;

  word_en_t          word_en;
  logic [DATA_W-1:0] regs_q  [NUM_STORED];
  logic [DATA_W-1:0] regs_d  [NUM_STORED];
  logic [DATA_W-1:0] rd_view [NUM_REGS];

  dec5_32_en u_dec (
    .en     (wr_en),
    .addr   (wr_addr),
    .onehot (word_en)
  );

  // The enable for X31 has no register to drive, which is what discards XZR writes.
  logic unused_xzr_we;
  assign unused_xzr_we = word_en[XZR_IDX];

  // Hold mux per register: load wr_data when its word enable is set, otherwise keep.
  always_comb begin
    for (int i = 0; i < NUM_STORED; i++) begin
      regs_d[i] = word_en[i] ? wr_data : regs_q[i];
    end
  end

  // Register bank; the asynchronous clear wins over any write in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: this storage is plain flops, so every word can be cleared by reset;
      // an SRAM macro could not be, and would need an explicit clearing sequence.
      for (int i = 0; i < NUM_STORED; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      for (int i = 0; i < NUM_STORED; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read view of all 32 addresses, with X31 hard-wired to zero.
  always_comb begin
    for (int i = 0; i < NUM_STORED; i++) begin
      rd_view[i] = regs_q[i];
    end
    rd_view[XZR_IDX] = '0;
  end

  // Reads are combinational, with no bypass from the write port.
  assign rd_data_a = rd_view[rd_addr_a];
  assign rd_data_b = rd_view[rd_addr_b];

endmodule

// File: tb/tb_regfile_32x64.sv
// Scoreboard bench for regfile_32x64: stimulus pushes expected read values
// computed from a behavioural array model; a negedge monitor pops and compares.
module tb_regfile_32x64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [63:0] rd_data_a;
  logic [63:0] rd_data_b;

  always #5 clk = ~clk;

  regfile_32x64 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b)
  );

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
  } exp_t;

  exp_t        exp_q[$];
  string       name_q[$];
  logic [63:0] mdl [32];
  int          checks = 0;
  int          errors = 0;

  // Architectural view: X31 is always zero, everything else is what was last written.
  function automatic logic [63:0] mdl_rd(input logic [4:0] ad);
    return (ad == 5'd31) ? 64'd0 : mdl[ad];
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle away from the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check({n, "_a"}, rd_data_a, e.a);
      check({n, "_b"}, rd_data_b, e.b);
    end
  end

  // One clock cycle of stimulus, entered 1 time unit after a rising edge.
  // rst_n_v=0 drops reset 2 units later, i.e. mid-cycle and before the monitor samples.
  task automatic cycle(input bit rst_n_v, input bit we, input logic [4:0] wa,
                       input logic [63:0] wd, input logic [4:0] ra, input logic [4:0] rb,
                       input string nm);
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    rd_addr_a = ra;
    rd_addr_b = rb;
    if (rst_n_v) begin
      reset_n = 1'b1;
    end else begin
      #2;
      reset_n = 1'b0;
      foreach (mdl[i]) mdl[i] = 64'd0;
    end
    exp_q.push_back(exp_t'{a: mdl_rd(ra), b: mdl_rd(rb)});
    name_q.push_back(nm);
    @(posedge clk);
    if (we && reset_n && wa != 5'd31) mdl[wa] = wd;
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    foreach (mdl[i]) mdl[i] = 64'd0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, and writes attempted during reset must not land.
    cycle(1'b0, 1'b1, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 5'd0, "rst_hold0");
    cycle(1'b0, 1'b1, 5'd0, 64'h1, 5'd30, 5'd31, "rst_hold1");
    // Release between edges; the write issued alongside lands at the very next edge.
    cycle(1'b1, 1'b1, 5'd0, 64'hAB, 5'd0, 5'd5, "rst_release");
    cycle(1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd5, "first_write");

    // One-hot coverage: Xi = i+1, reading the previous write back as we go.
    for (int i = 0; i < 31; i++) begin
      cycle(1'b1, 1'b1, 5'(i), 64'(i + 1), 5'(i == 0 ? 0 : i - 1), 5'd31, "onehot_wr");
    end
    for (int i = 0; i < 31; i += 2) begin
      cycle(1'b1, 1'b0, 5'd0, 64'h0, 5'(i), 5'(i + 1), "onehot_rd");
    end

    // XZR: write is dropped and reads stay zero.
    cycle(1'b1, 1'b1, 5'd31, 64'hDEAD_BEEF_DEAD_BEEF, 5'd30, 5'd31, "xzr_wr");
    cycle(1'b1, 1'b0, 5'd31, 64'h0, 5'd31, 5'd31, "xzr_rd");

    // Enable gating: X7 keeps 0x1234 when wr_en is low.
    cycle(1'b1, 1'b1, 5'd7, 64'h1234, 5'd7, 5'd6, "gate_setup");
    cycle(1'b1, 1'b0, 5'd7, 64'hAAAA_AAAA_AAAA_AAAA, 5'd7, 5'd7, "gate_off");
    cycle(1'b1, 1'b0, 5'd7, 64'hAAAA_AAAA_AAAA_AAAA, 5'd7, 5'd8, "gate_after");

    // Write/readback of X5, then sweep every register for collateral damage.
    cycle(1'b1, 1'b1, 5'd5, 64'h0123_4567_89AB_CDEF, 5'd4, 5'd6, "x5_wr");
    for (int i = 0; i < 32; i += 2) begin
      cycle(1'b1, 1'b0, 5'd0, 64'h0, 5'(i + 1 == 32 ? 5 : i + 1), 5'(i), "x5_sweep");
    end

    // Same-cycle read/write: old value before the edge, new value after, both ports agree.
    cycle(1'b1, 1'b1, 5'd9, 64'h11, 5'd9, 5'd10, "rw_setup");
    cycle(1'b1, 1'b1, 5'd9, 64'h22, 5'd9, 5'd9, "rw_before");
    cycle(1'b1, 1'b0, 5'd9, 64'h0, 5'd9, 5'd9, "rw_after");

    // Randomized traffic against the array model.
    for (int n = 0; n < 300; n++) begin
      cycle(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            {$urandom, $urandom}, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            "random");
    end

    // Fill X0..X30 with all ones, then drop reset mid-cycle during a write to X3.
    for (int i = 0; i < 31; i++) begin
      cycle(1'b1, 1'b1, 5'(i), 64'hFFFF_FFFF_FFFF_FFFF, 5'(i), 5'(30 - i), "fill_ones");
    end
    cycle(1'b0, 1'b1, 5'd3, 64'h5555_5555_5555_5555, 5'd3, 5'd30, "rst_async");
    for (int n = 0; n < 4; n++) begin
      cycle(1'b0, 1'b1, 5'($urandom_range(0, 30)), 64'hFFFF_FFFF_FFFF_FFFF,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "rst_low");
    end
    cycle(1'b1, 1'b0, 5'd0, 64'h0, 5'd3, 5'd0, "rst_release2");
    for (int i = 0; i < 32; i += 2) begin
      cycle(1'b1, 1'b0, 5'd0, 64'h0, 5'(i), 5'(i + 1), "post_rst_sweep");
    end

    // Bounded drain of the scoreboard before reporting.
    for (int n = 0; n < 4 && exp_q.size() != 0; n++) begin
      @(negedge clk);
      #1;
    end
    check("scoreboard_drain", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
